// File: rtl/reg_xfer_seq_pkg.sv
// Shared definitions for the register-transfer sequencer: opcodes, FSM
// state encoding, register-file geometry and index arithmetic.
package reg_xfer_seq_pkg;

  localparam int NUM_REGS = 8;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    OP_MOV   = 2'b00,
    OP_SWAP  = 2'b01,
    OP_BLOCK = 2'b10,
    OP_RSV   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_XFER = 3'd1,
    ST_SW1  = 3'd2,
    ST_SW2  = 3'd3,
    ST_SW3  = 3'd4,
    ST_BLK  = 3'd5
  } state_e;

  // Register index addition; wraps modulo NUM_REGS through the index width.
  function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base,
                                               input logic [IDX_W-1:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/reg_idx_cnt.sv
// Wrapping register-index counter used to step through a BLOCK transfer.
// Reset and clear force zero; without inc the value holds.
module reg_idx_cnt
  import reg_xfer_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] cnt_o
);

  logic [IDX_W-1:0] cnt_q;

  // Counter register: reset/clear to zero, advance on inc, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= idx_add(cnt_q, IDX_W'(1));
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_xfer_seq.sv
// Register-transfer sequencer: accepts MOV / SWAP / BLOCK commands and
// drives the register-file bus enables and indices cycle by cycle.
// Bus outputs are registered one cycle ahead of use; stall holds all
// state and masks the registered outputs in the stalled cycle.
module reg_xfer_seq
  import reg_xfer_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [1:0]       cmdOp,
  input  logic [IDX_W-1:0] cmdSrc,
  input  logic [IDX_W-1:0] cmdDst,
  input  logic [IDX_W-1:0] cmdCount,
  input  logic             stall,
  output logic             oe,
  output logic             load,
  output logic [1:0]       oeSourceSel,
  output logic             loadSourceSel,
  output logic [IDX_W-1:0] useqRegSelOE,
  output logic [IDX_W-1:0] useqRegSelLoad,
  output logic             tmpOE,
  output logic             tmpLoad,
  output logic             done,
  output logic             err
);

  state_e           state_q;
  op_e              op_q;
  logic [IDX_W-1:0] src_q, dst_q, count_q;
  logic             ready_q;
  logic             oe_q, load_q, tmp_oe_q, tmp_load_q, done_q;
  logic [IDX_W-1:0] sel_oe_q, sel_load_q;

  logic             stall_act;
  logic             accept;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] cnt_nxt;
  logic             blk_inc;

  assign stall_act = stall && (state_q != ST_IDLE);
  assign accept    = (state_q == ST_IDLE) && cmdValid && ready_q;
  assign cnt_nxt   = idx_add(cnt, IDX_W'(1));
  assign blk_inc   = (state_q == ST_BLK) && !stall && (cnt != count_q);

  reg_idx_cnt u_idx_cnt (
    .clk   (clock),
    .rst   (reset),
    .clr   (accept),
    .inc   (blk_inc),
    .cnt_o (cnt)
  );

  // Sequencer FSM: state, latched command and next-cycle bus outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_MOV;
      src_q      <= '0;
      dst_q      <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      oe_q       <= 1'b0;
      load_q     <= 1'b0;
      tmp_oe_q   <= 1'b0;
      tmp_load_q <= 1'b0;
      done_q     <= 1'b0;
      sel_oe_q   <= '0;
      sel_load_q <= '0;
    end else if (!stall_act) begin
      // Bus activity is a one-cycle pulse unless a branch below re-arms it.
      oe_q       <= 1'b0;
      load_q     <= 1'b0;
      tmp_oe_q   <= 1'b0;
      tmp_load_q <= 1'b0;
      done_q     <= 1'b0;
      sel_oe_q   <= '0;
      sel_load_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= op_e'(cmdOp);
            src_q   <= cmdSrc;
            dst_q   <= cmdDst;
            count_q <= cmdCount;
            ready_q <= 1'b0;
            case (op_e'(cmdOp))
              OP_MOV: begin
                state_q    <= ST_XFER;
                oe_q       <= 1'b1;
                load_q     <= 1'b1;
                sel_oe_q   <= cmdSrc;
                sel_load_q <= cmdDst;
                done_q     <= 1'b1;
              end
              OP_SWAP: begin
                if (cmdSrc == cmdDst) begin
                  // Self-swap is a no-op: a single quiet cycle that completes.
                  state_q <= ST_SW3;
                  done_q  <= 1'b1;
                end else begin
                  state_q    <= ST_SW1;
                  oe_q       <= 1'b1;
                  sel_oe_q   <= cmdSrc;
                  tmp_load_q <= 1'b1;
                end
              end
              OP_BLOCK: begin
                state_q    <= ST_BLK;
                oe_q       <= 1'b1;
                load_q     <= 1'b1;
                sel_oe_q   <= cmdSrc;
                sel_load_q <= cmdDst;
                done_q     <= (cmdCount == '0);
              end
              default: begin
                // Reserved opcode: one completion cycle flagged as an error.
                state_q <= ST_XFER;
                done_q  <= 1'b1;
              end
            endcase
          end
        end
        ST_SW1: begin
          state_q    <= ST_SW2;
          oe_q       <= 1'b1;
          sel_oe_q   <= dst_q;
          load_q     <= 1'b1;
          sel_load_q <= src_q;
        end
        ST_SW2: begin
          state_q    <= ST_SW3;
          tmp_oe_q   <= 1'b1;
          load_q     <= 1'b1;
          sel_load_q <= dst_q;
          done_q     <= 1'b1;
        end
        ST_BLK: begin
          if (cnt == count_q) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            oe_q       <= 1'b1;
            load_q     <= 1'b1;
            sel_oe_q   <= idx_add(src_q, cnt_nxt);
            sel_load_q <= idx_add(dst_q, cnt_nxt);
            done_q     <= (cnt_nxt == count_q);
          end
        end
        default: begin
          // XFER and SW3 are single terminal cycles.
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // A stalled cycle shows no bus activity; the held registers replay afterwards.
  assign cmdReady       = ready_q;
  assign oe             = oe_q & ~stall_act;
  assign load           = load_q & ~stall_act;
  assign tmpOE          = tmp_oe_q & ~stall_act;
  assign tmpLoad        = tmp_load_q & ~stall_act;
  assign done           = done_q & ~stall_act;
  assign err            = (state_q == ST_XFER) && (op_q == OP_RSV) && !stall_act;
  assign useqRegSelOE   = stall_act ? '0 : sel_oe_q;
  assign useqRegSelLoad = stall_act ? '0 : sel_load_q;
  assign oeSourceSel    = 2'b00;
  assign loadSourceSel  = 1'b0;

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Directed bench for reg_xfer_seq: each bus cycle is compared against a
// hand-written vector {oe,load,tmpOE,tmpLoad,done,err,OEidx,LOADidx}.
module tb_reg_xfer_seq;

  logic       clock = 1'b0;
  logic       reset, cmdValid, cmdReady, stall;
  logic [1:0] cmdOp;
  logic [2:0] cmdSrc, cmdDst, cmdCount;
  logic       oe, load, loadSourceSel, tmpOE, tmpLoad, done, err;
  logic [1:0] oeSourceSel;
  logic [2:0] useqRegSelOE, useqRegSelLoad;

  int errs   = 0;
  int checks = 0;

  reg_xfer_seq dut (
    .clock          (clock),
    .reset          (reset),
    .cmdValid       (cmdValid),
    .cmdReady       (cmdReady),
    .cmdOp          (cmdOp),
    .cmdSrc         (cmdSrc),
    .cmdDst         (cmdDst),
    .cmdCount       (cmdCount),
    .stall          (stall),
    .oe             (oe),
    .load           (load),
    .oeSourceSel    (oeSourceSel),
    .loadSourceSel  (loadSourceSel),
    .useqRegSelOE   (useqRegSelOE),
    .useqRegSelLoad (useqRegSelLoad),
    .tmpOE          (tmpOE),
    .tmpLoad        (tmpLoad),
    .done           (done),
    .err            (err)
  );

  always #5 clock = ~clock;

  logic [11:0] bus;
  assign bus = {oe, load, tmpOE, tmpLoad, done, err, useqRegSelOE, useqRegSelLoad};

  function automatic logic [11:0] bv(input bit o, input bit l, input bit to,
                                     input bit tl, input bit d, input bit e,
                                     input logic [2:0] so, input logic [2:0] sl);
    return {o, l, to, tl, d, e, so, sl};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] s,
                       input logic [2:0] d, input logic [2:0] c);
    cmdValid = 1'b1; cmdOp = op; cmdSrc = s; cmdDst = d; cmdCount = c;
    tick();
    cmdValid = 1'b0; cmdOp = 2'b00; cmdSrc = 3'd0; cmdDst = 3'd0; cmdCount = 3'd0;
  endtask

  initial begin
    reset = 1'b1; cmdValid = 1'b0; stall = 1'b0;
    cmdOp = 2'b00; cmdSrc = 3'd0; cmdDst = 3'd0; cmdCount = 3'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", cmdReady, 1);
    chk("rst_bus", bus, 0);
    chk("rst_oesel", oeSourceSel, 0);
    chk("rst_ldsel", loadSourceSel, 0);

    // MOV 3 -> 5
    issue(2'b00, 3'd3, 3'd5, 3'd0);
    chk("mov_bus", bus, bv(1, 1, 0, 0, 1, 0, 3'd3, 3'd5));
    chk("mov_busy", cmdReady, 0);
    tick();
    chk("mov_ready", cmdReady, 1);
    chk("mov_idle", bus, 0);

    // SWAP 1 <-> 6
    issue(2'b01, 3'd1, 3'd6, 3'd0);
    chk("sw1", bus, bv(1, 0, 0, 1, 0, 0, 3'd1, 3'd0));
    tick();
    chk("sw2", bus, bv(1, 1, 0, 0, 0, 0, 3'd6, 3'd1));
    tick();
    chk("sw3", bus, bv(0, 1, 1, 0, 1, 0, 3'd0, 3'd6));
    tick();
    chk("sw_ready", cmdReady, 1);
    chk("sw_idle", bus, 0);

    // SWAP 2 <-> 2
    issue(2'b01, 3'd2, 3'd2, 3'd0);
    chk("swself", bus, bv(0, 0, 0, 0, 1, 0, 3'd0, 3'd0));
    tick();
    chk("swself_ready", cmdReady, 1);
    chk("swself_idle", bus, 0);

    // BLOCK src=6 dst=0 count=3, wrapping source
    issue(2'b10, 3'd6, 3'd0, 3'd3);
    chk("blk0", bus, bv(1, 1, 0, 0, 0, 0, 3'd6, 3'd0));
    tick();
    chk("blk1", bus, bv(1, 1, 0, 0, 0, 0, 3'd7, 3'd1));
    tick();
    chk("blk2", bus, bv(1, 1, 0, 0, 0, 0, 3'd0, 3'd2));
    tick();
    chk("blk3", bus, bv(1, 1, 0, 0, 1, 0, 3'd1, 3'd3));
    tick();
    chk("blk_ready", cmdReady, 1);
    chk("blk_idle", bus, 0);

    // BLOCK count=0: single transfer with done
    issue(2'b10, 3'd4, 3'd7, 3'd0);
    chk("blk1x", bus, bv(1, 1, 0, 0, 1, 0, 3'd4, 3'd7));
    tick();
    chk("blk1x_idle", bus, 0);

    // BLOCK src=2 dst=4 count=2, stalled for two cycles after the first transfer
    issue(2'b10, 3'd2, 3'd4, 3'd2);
    chk("bst0", bus, bv(1, 1, 0, 0, 0, 0, 3'd2, 3'd4));
    tick();
    stall = 1'b1;
    #1;
    chk("bst_stall1", bus, 0);
    chk("bst_stall1_rdy", cmdReady, 0);
    tick();
    chk("bst_stall2", bus, 0);
    tick();
    stall = 1'b0;
    #1;
    chk("bst1", bus, bv(1, 1, 0, 0, 0, 0, 3'd3, 3'd5));
    tick();
    chk("bst2", bus, bv(1, 1, 0, 0, 1, 0, 3'd4, 3'd6));
    tick();
    chk("bst_ready", cmdReady, 1);
    chk("bst_idle", bus, 0);

    // Stall in IDLE does not block acceptance: MOV 7 -> 0
    stall = 1'b1;
    issue(2'b00, 3'd7, 3'd0, 3'd0);
    stall = 1'b0;
    #1;
    chk("stall_idle_mov", bus, bv(1, 1, 0, 0, 1, 0, 3'd7, 3'd0));
    tick();
    chk("stall_idle_ready", cmdReady, 1);

    // Reserved opcode
    issue(2'b11, 3'd5, 3'd2, 3'd4);
    chk("rsv_bus", bus, bv(0, 0, 0, 0, 1, 1, 3'd0, 3'd0));
    chk("rsv_busy", cmdReady, 0);
    tick();
    chk("rsv_ready", cmdReady, 1);
    chk("rsv_idle", bus, 0);

    // Reset during SW2 abandons the swap
    issue(2'b01, 3'd0, 3'd4, 3'd0);
    chk("rsw1", bus, bv(1, 0, 0, 1, 0, 0, 3'd0, 3'd0));
    tick();
    chk("rsw2", bus, bv(1, 1, 0, 0, 0, 0, 3'd4, 3'd0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rsw_ready", cmdReady, 1);
    chk("rsw_bus", bus, 0);
    tick();
    chk("rsw_quiet", bus, 0);
    chk("rsw_ready2", cmdReady, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
